decodificador_varredura: RTL
============================

# decodificador_varredura

Parametrised, registered one-hot decoder with an automatic scan mode. It is the next generation of the team's 3-to-8 decoder: input width is generic, outputs are registered, and an enable plus a scan mode step the active line through every position with a programmable dwell time. It targets display-digit multiplexing and row-select sequencing, fed either by a datapath index or by its own internal counter.

## Interface
Parameters:
- W, default 3: index width; output width is N = 2**W.
- DWELL, default 4: clock cycles each position stays active in scan mode; legal range ≥ 1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset; one clock; no asynchronous behaviour.
- en  in  1  enable; 0 blanks `d` and freezes `idx` and the dwell counter.
- modo  in  1  0 = direct decode of `a`; 1 = automatic scan.
- a  in  W  index to decode in direct mode; ignored in scan mode.
- d  out  N  one-hot (or all-zero) registered output.
- idx  out  W  registered index currently held.
- fim  out  1  one-cycle pulse when the scan wraps from N-1 to 0.

## Operation
Mapping (unchanged from the existing decoder family):
- Index k asserts `d[N-1-k]`. For W=3: k=0 gives `d`=8'b1000_0000; k=7 gives 8'b0000_0001.
- At most one bit of `d` is ever high.

Reset (`rst`=1 at a clock edge): `d`=0, `idx`=0, `fim`=0, dwell counter `cnt`=0. Reset overrides `en`, `modo` and `a`, including mid-scan.

Per clock edge, with `rst`=0 and priority top-down:
- `en`=0: `d`<=0; `idx` and `cnt` hold; `fim`<=0.
- `en`=1, `modo`=0 (direct): `idx`<=`a`; `cnt`<=0; `d`<=onehot(`a`); `fim`<=0.
- `en`=1, `modo`=1 (scan):
  - If `cnt`<DWELL-1: `cnt`<=`cnt`+1; `idx` holds; `d`<=onehot(`idx`); `fim`<=0.
  - If `cnt`=DWELL-1: `cnt`<=0; `idx`<=`idx`+1 modulo N; `d`<=onehot(`idx`+1 mod N); `fim`<=1 only when `idx`=N-1 (wrap), otherwise 0.

Arithmetic and widths:
- `cnt` width is max(1, $clog2(DWELL)).
- `idx` increments wrap naturally in W bits.
- DWELL=1 steps the index every enabled scan cycle.

Boundary conditions:
- Direct to scan: the scan starts from the current `idx` with `cnt`=0. That position gets a full DWELL cycles.
- Scan to direct: `a` takes effect at the next edge; the partial dwell is discarded.
- `en` dropping mid-dwell: resumes with the same `idx`/`cnt` when `en` returns. `d` is 0 while disabled and re-asserts onehot(`idx`) on the first enabled edge.
- `fim` never asserts in direct mode or when disabled, even if `a` jumps from N-1 to 0.

## Timing
- All outputs are registered, with a 1-cycle latency from inputs to `d`/`idx`/`fim`.
- `d` always equals onehot(`idx`) when the previous edge had `en`=1, and 0 otherwise. It is never stale against `idx`.
- Scan period is N×DWELL enabled cycles. `fim` is high for exactly one cycle per period, the same cycle `idx` first shows 0.
- No combinational path from any input to any output.

## Test plan
(W=3, DWELL=4 unless stated)
- Reset/direct: `rst`=1 for 1 cycle, then `en`=1, `modo`=0, `a`=0..7 one per cycle. Required: `d`=0, `idx`=0 during reset; then `d`=8'h80, 8'h40, …, 8'h01 one cycle after each `a`. `fim` stays 0.
- Scan: `en`=1, `modo`=1 from `idx`=0. Required: `idx` steps every 4 cycles through 0,1,…,7,0. `fim`=1 only in the cycle `idx` returns to 0 (32 cycles after the first step at `idx`=0). `d` tracks `idx`.
- Enable gap: during scan at `idx`=5, `cnt`=2, drop `en` for 3 cycles. Required: `d`=0 during the gap; `idx`=5. After re-enable, `d`=8'h04 for 1 more cycle, then `idx`=6.
- Mode switch: scanning at `idx`=3, set `modo`=0 with `a`=6. Required: next cycle `idx`=6, `d`=8'h02. Back to `modo`=1: `idx`=6 is held 4 cycles, then 7.
- Reset mid-scan: `rst` asserted at `idx`=7, `cnt`=3. Required: next cycle `idx`=0, `d`=0, `fim`=0 (no wrap pulse).
- DWELL=1, W=2: scan gives `idx` 0,1,2,3,0 on consecutive cycles. `d`=4'b1000, 0100, 0010, 0001. `fim` pulses every 4th cycle.

Source files
------------

// File: rtl/decodificador_varredura.sv
// rtl/decodificador_varredura.sv - registered one-hot decoder with automatic scan mode
//
// Index k drives d[N-1-k]. In direct mode the index comes from a; in scan
// mode an internal counter dwells DWELL enabled cycles per position and
// steps through all N positions, pulsing fim on the wrap N-1 -> 0.
//
// Ports:
//   clk   in  1   clock, rising edge
//   rst   in  1   synchronous active-high reset
//   en    in  1   enable; 0 blanks d and freezes idx / dwell counter
//   modo  in  1   0 = direct decode of a, 1 = automatic scan
//   a     in  W   index for direct mode
//   d     out N   registered one-hot (or all-zero) output
//   idx   out W   registered index currently held
//   fim   out 1   one-cycle pulse on scan wrap
module decodificador_varredura #(
    parameter int W     = 3,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              modo,
    input  logic [W-1:0]      a,
    output logic [2**W-1:0]   d,
    output logic [W-1:0]      idx,
    output logic              fim
);

    localparam int N  = 2**W;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [N-1:0]  d_q,   d_d;
    logic [W-1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fim_q, fim_d;
    logic [W-1:0]  idx_nxt;

    // Reversed bit order keeps the mapping of the existing decoder family.
    function automatic logic [N-1:0] onehot(input logic [W-1:0] k);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[N-1-i] = (k == W'(i));
        end
        return v;
    endfunction

    // Wraps naturally in W bits.
    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        d_d   = '0;
        idx_d = idx_q;
        cnt_d = cnt_q;
        fim_d = 1'b0;
        if (en) begin
            if (!modo) begin
                // Direct: any partial dwell is discarded so a later scan
                // gives this position a full DWELL cycles.
                idx_d = a;
                cnt_d = '0;
                d_d   = onehot(a);
            end else if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + 1'b1;
                d_d   = onehot(idx_q);
            end else begin
                cnt_d = '0;
                idx_d = idx_nxt;
                d_d   = onehot(idx_nxt);
                fim_d = (idx_q == {W{1'b1}});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q   <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            fim_q <= 1'b0;
        end else begin
            d_q   <= d_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            fim_q <= fim_d;
        end
    end

    assign d   = d_q;
    assign idx = idx_q;
    assign fim = fim_q;

endmodule
